// File: rtl/cfg_chain_pkg.sv
// cfg_chain_pkg: shared definitions for the configuration-chain loader.
//   - cfg_state_e           : loader state encoding (IDLE, SHIFT, VERIFY, DONE)
//   - CFG_CHAIN_LEN_DEFAULT : default number of bits in the target chain
package cfg_chain_pkg;

  localparam int CFG_CHAIN_LEN_DEFAULT = 69;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_piso.sv
// cfg_piso: parallel-load, LSB-first shadow register for the chain image.
// Ports:
//   clk       in  : clock
//   rst_n     in  : asynchronous active-low reset
//   load      in  : capture load_data (highest priority)
//   load_data in  : WIDTH-bit image
//   shift     in  : shift right by one, zero fill (image consumed)
//   rotate    in  : rotate right by one (image preserved after WIDTH steps)
//   head      out : bit currently at position 0
//   next_bit  out : bit that will be at position 0 after the next shift/rotate
module cfg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             rotate,
  output logic             head,
  output logic             next_bit
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;

  // Next shadow contents: load wins over rotate, rotate over shift.
  always_comb begin
    if (load) begin
      data_nxt_s = load_data;
    end else if (rotate) begin
      data_nxt_s = {data_r[0], data_r[WIDTH-1:1]};
    end else if (shift) begin
      data_nxt_s = {1'b0, data_r[WIDTH-1:1]};
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Shadow register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
    end else begin
      data_r <= data_nxt_s;
    end
  end

  assign head     = data_r[0];
  assign next_bit = data_r[1];

endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: transmit side of the serial configuration chain.
// Captures a parallel image on start and shifts it LSB-first into the chain
// with prog_en high for exactly CHAIN_LEN cycles, then pulses done.
// Optional macro CFG_READBACK_VERIFY_EN adds a VERIFY pass that re-shifts the
// image while comparing prog_out against it; mismatches set verify_err.
// Ports:
//   prog_clk   in  : configuration clock
//   rst_n      in  : asynchronous active-low reset
//   start      in  : load request, sampled only in IDLE
//   bitstream  in  : image, bit 0 shifted first
//   abort      in  : cancel an active pass
//   busy       out : load/verify in progress
//   done       out : one-cycle completion pulse
//   prog_in    out : serial data to chain head
//   prog_en    out : chain shift enable
//   prog_out   in  : serial data from chain tail (verify only)
//   verify_err out : sticky readback mismatch flag
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = CFG_CHAIN_LEN_DEFAULT,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] bitstream,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 prog_in,
  output logic                 prog_en,
  input  logic                 prog_out,
  output logic                 verify_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  cfg_state_e       state_r;
  cfg_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic accept_s;
  logic active_s;
  logic last_bit_s;
  logic piso_shift_s;
  logic piso_rotate_s;
  logic piso_head_s;
  logic piso_next_s;

  logic busy_nxt_s;
  logic done_nxt_s;
  logic prog_in_nxt_s;
  logic prog_en_nxt_s;
  logic verify_err_nxt_s;
  logic busy_r;
  logic done_r;
  logic prog_in_r;
  logic prog_en_r;
  logic verify_err_r;

  assign accept_s   = (state_r == IDLE) && start;
  assign active_s   = (state_r == SHIFT) || (state_r == VERIFY);
  assign last_bit_s = (cnt_r == CNT_LAST);

`ifdef CFG_READBACK_VERIFY_EN
  // Rotating keeps the image intact so the verify pass can replay it.
  assign piso_rotate_s = active_s;
  assign piso_shift_s  = 1'b0;
`else
  assign piso_rotate_s = 1'b0;
  assign piso_shift_s  = active_s;
`endif

  cfg_piso #(
    .WIDTH(CHAIN_LEN)
  ) u_piso (
    .clk      (prog_clk),
    .rst_n    (rst_n),
    .load     (accept_s),
    .load_data(bitstream),
    .shift    (piso_shift_s),
    .rotate   (piso_rotate_s),
    .head     (piso_head_s),
    .next_bit (piso_next_s)
  );

  // State and bit-counter registers.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; abort forces a single DONE cycle from any active pass.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt_s = DONE;
        end else if (last_bit_s) begin
`ifdef CFG_READBACK_VERIFY_EN
          state_nxt_s = VERIFY;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = SHIFT;
        end
      end
`ifdef CFG_READBACK_VERIFY_EN
      VERIFY: begin
        if (abort || last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = VERIFY;
        end
      end
`endif
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bit counter: advances while shifting, wraps to 0 on every pass exit.
  always_comb begin
    if (active_s && !abort && !last_bit_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Output decode from the upcoming state so outputs can be registered.
  always_comb begin
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    prog_en_nxt_s = 1'b0;
    prog_in_nxt_s = 1'b0;
    case (state_nxt_s)
      SHIFT, VERIFY: begin
        busy_nxt_s    = 1'b1;
        prog_en_nxt_s = 1'b1;
        // On the accepting edge the shadow is not loaded yet; take bit 0 direct.
        if (accept_s) begin
          prog_in_nxt_s = bitstream[0];
        end else begin
          prog_in_nxt_s = piso_next_s;
        end
      end
      DONE: begin
        done_nxt_s = 1'b1;
      end
      IDLE: begin
        done_nxt_s = 1'b0;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

`ifdef CFG_READBACK_VERIFY_EN
  // Sticky readback compare: the shadow head is the bit now leaving the tail.
  always_comb begin
    if (accept_s) begin
      verify_err_nxt_s = 1'b0;
    end else if ((state_r == VERIFY) && !abort && (prog_out != piso_head_s)) begin
      verify_err_nxt_s = 1'b1;
    end else begin
      verify_err_nxt_s = verify_err_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{prog_out, piso_head_s};

  // Readback disabled: the error flag never sets.
  always_comb begin
    verify_err_nxt_s = 1'b0;
  end
`endif

  // Output registers.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      prog_in_r    <= 1'b0;
      prog_en_r    <= 1'b0;
      verify_err_r <= 1'b0;
    end else begin
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      prog_in_r    <= prog_in_nxt_s;
      prog_en_r    <= prog_en_nxt_s;
      verify_err_r <= verify_err_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign prog_in    = prog_in_r;
  assign prog_en    = prog_en_r;
  assign verify_err = verify_err_r;

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
// Self-checking bench: an 8-bit and a 69-bit loader, each driving a behavioural
// chain shift-register model fed back to prog_out.
module tb_cfg_chain_loader;

  localparam int L8  = 8;
  localparam int L69 = 69;
`ifdef CFG_READBACK_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int P8  = PASSES * L8;
  localparam int P69 = PASSES * L69;
  localparam bit VERIFY_ON = (PASSES == 2);

  logic prog_clk = 1'b0;
  logic rst_n    = 1'b1;
  always #5 prog_clk = ~prog_clk;

  logic        start8, abort8, busy8, done8, in8, en8, pout8, err8;
  logic [7:0]  bs8;
  logic        start69, abort69, busy69, done69, in69, en69, pout69, err69;
  logic [68:0] bs69;

  logic [7:0]  chain8  = 8'h00;
  logic [7:0]  stuck8  = 8'h00;
  logic [68:0] chain69 = 69'd0;

  logic [4:0] obs8;
  assign obs8 = {en8, busy8, done8, in8, err8};

  int total_cnt = 0;
  int pass_cnt  = 0;

  cfg_chain_loader #(.CHAIN_LEN(L8)) u_dut8 (
    .prog_clk(prog_clk), .rst_n(rst_n), .start(start8), .bitstream(bs8),
    .abort(abort8), .busy(busy8), .done(done8), .prog_in(in8),
    .prog_en(en8), .prog_out(pout8), .verify_err(err8)
  );

  cfg_chain_loader u_dut69 (
    .prog_clk(prog_clk), .rst_n(rst_n), .start(start69), .bitstream(bs69),
    .abort(abort69), .busy(busy69), .done(done69), .prog_in(in69),
    .prog_en(en69), .prog_out(pout69), .verify_err(err69)
  );

  // Chain models: prog_in enters the head (top), tail is bit 0; stuck cells read 0.
  always @(posedge prog_clk) begin
    if (en8) chain8 <= {in8, chain8[7:1]} & ~stuck8;
    if (en69) chain69 <= {in69, chain69[68:1]};
  end
  assign pout8  = chain8[0];
  assign pout69 = chain69[0];

  // Reference: {prog_en, busy, done, prog_in, verify_err} sampled after edge T0+c.
  function automatic logic [4:0] exp8(input logic [7:0] img, input int c, input logic err);
    if (c < P8) return {3'b110, img[c % L8], err};
    else if (c == P8) return {4'b0010, err};
    else return {4'b0000, err};
  endfunction

  task automatic test_reset();
    start8 = 1'b0; abort8 = 1'b0; bs8 = 8'h00;
    start69 = 1'b0; abort69 = 1'b0; bs69 = 69'd0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obs8 !== 5'b00000) $display("FAIL reset8: got %b expected %b", obs8, 5'b00000);
    else pass_cnt++;
    total_cnt++;
    if ({en69, busy69, done69, in69, err69} !== 5'b00000)
      $display("FAIL reset69: got %b expected %b", {en69, busy69, done69, in69, err69}, 5'b00000);
    else pass_cnt++;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk) rst_n = 1'b1;
    @(posedge prog_clk); #1;
    total_cnt++;
    if (obs8 !== 5'b00000) $display("FAIL reset_idle: got %b expected %b", obs8, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_pattern_a5();
    logic [4:0] e;
    start8 = 1'b1; bs8 = 8'hA5;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0; bs8 = 8'($urandom);
      e = exp8(8'hA5, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL a5_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_loads();
    logic [7:0] img;
    logic [4:0] e;
    for (int n = 0; n < 4; n++) begin
      img = 8'($urandom);
      start8 = 1'b1; bs8 = img;
      for (int c = 0; c <= P8 + 1; c++) begin
        @(posedge prog_clk); #1;
        start8 = 1'b0; bs8 = 8'($urandom);
        e = exp8(img, c, 1'b0);
        total_cnt++;
        if (obs8 !== e) $display("FAIL rand%0d_c%0d: got %b expected %b", n, c, obs8, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] img;
    logic [4:0] e;
    img = 8'($urandom);
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL busy_start_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
      bs8    = ~img;
      start8 = (c == 2) || (c == 4);
    end
    start8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] imga, imgc;
    logic [4:0] e;
    imga = 8'($urandom); imgc = ~imga;
    start8 = 1'b1; bs8 = imga;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      e = exp8(imga, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL b2b_first_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
      bs8    = imgc;
      start8 = (c >= P8 - 1);
    end
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(imgc, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL b2b_second_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] img;
    logic [4:0] e;
    img = 8'($urandom);
    start8 = 1'b1; abort8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0; abort8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL start_abort_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
    img = 8'($urandom);
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c < 4; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL pre_abort_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
    abort8 = 1'b1;
    @(posedge prog_clk); #1;
    total_cnt++;
    if (obs8 !== 5'b00100) $display("FAIL abort_done: got %b expected %b", obs8, 5'b00100);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(posedge prog_clk); #1;
      total_cnt++;
      if (obs8 !== 5'b00000) $display("FAIL abort_idle%0d: got %b expected %b", c, obs8, 5'b00000);
      else pass_cnt++;
    end
    abort8 = 1'b0;
    img = 8'($urandom);
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL post_abort_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] img;
    logic [4:0] e;
    img = 8'($urandom) | 8'h01;
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c < 3; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL pre_rst_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obs8 !== 5'b00000) $display("FAIL arst_immediate: got %b expected %b", obs8, 5'b00000);
    else pass_cnt++;
    @(posedge prog_clk); #1;
    total_cnt++;
    if (obs8 !== 5'b00000) $display("FAIL arst_held: got %b expected %b", obs8, 5'b00000);
    else pass_cnt++;
    @(negedge prog_clk) rst_n = 1'b1;
    @(posedge prog_clk); #1;
    total_cnt++;
    if (obs8 !== 5'b00000) $display("FAIL arst_idle: got %b expected %b", obs8, 5'b00000);
    else pass_cnt++;
    img = 8'($urandom);
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL post_rst_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_chain69();
    logic [68:0] img;
    int en_cnt;
    for (int i = 0; i < L69; i++) img[i] = 1'($urandom_range(0, 1));
    en_cnt = 0;
    start69 = 1'b1; bs69 = img;
    for (int c = 0; c <= P69 + 1; c++) begin
      @(posedge prog_clk); #1;
      start69 = 1'b0; bs69 = ~img;
      if (en69) en_cnt++;
      if (c == P69) begin
        total_cnt++;
        if (done69 !== 1'b1) $display("FAIL chain69_done: got %b expected %b", done69, 1'b1);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (chain69 !== img) $display("FAIL chain69_image: got %h expected %h", chain69, img);
    else pass_cnt++;
    total_cnt++;
    if (en_cnt != P69) $display("FAIL chain69_en_cycles: got %0d expected %0d", en_cnt, P69);
    else pass_cnt++;
    total_cnt++;
    if ({busy69, err69} !== 2'b00) $display("FAIL chain69_idle: got %b expected %b", {busy69, err69}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_verify();
    logic [7:0] img;
    logic [4:0] e;
    logic [4:0] o;
    int p;
    p = $urandom_range(0, 7);
    img = 8'($urandom) | (8'h01 << p);
    stuck8 = 8'h01 << p;
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      o = obs8;
      total_cnt++;
      if (o[4:1] !== e[4:1]) $display("FAIL stuck_c%0d: got %b expected %b", c, o[4:1], e[4:1]);
      else pass_cnt++;
    end
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (err8 !== VERIFY_ON) $display("FAIL stuck_err%0d: got %b expected %b", c, err8, VERIFY_ON);
      else pass_cnt++;
      @(posedge prog_clk); #1;
    end
    stuck8 = 8'h00;
    img = 8'($urandom);
    start8 = 1'b1; bs8 = img;
    for (int c = 0; c <= P8 + 1; c++) begin
      @(posedge prog_clk); #1;
      start8 = 1'b0;
      e = exp8(img, c, 1'b0);
      total_cnt++;
      if (obs8 !== e) $display("FAIL err_clear_c%0d: got %b expected %b", c, obs8, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_pattern_a5();
    test_random_loads();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_chain69();
    test_verify();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
